// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud/frame timing helpers
// used by uart_tx_arb, uart_tx and uart_rx.
package uart_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_LOAD = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return clk_freq / bps;
    endfunction

    // One frame is start + 8 data + stop bits.
    function automatic int unsigned frame_cycles(input int unsigned clk_freq,
                                                 input int unsigned bps);
        return 10 * baud_cnt_max(clk_freq, bps);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker; search starts one past
// the last grant and wraps modulo N_REQ.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic [IW-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(last_i) + k) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx among N_REQ producers.
// Optional packet lock is built when UART_ARB_LOCK_EN is defined.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned UART_BPS = 9600,
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [7:0]               pi_data,
    output logic                     pi_flag,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int unsigned IW           = $clog2(N_REQ);
    localparam int unsigned FRAME_CYCLES = frame_cycles(CLK_FREQ, UART_BPS);
    localparam int unsigned CW           = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_CYCLES - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [7:0]    data_q, data_d;

    logic [7:0]    req_byte [N_REQ];
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] rr_last;
    logic          sel_valid;
    logic [IW-1:0] sel_idx;
    logic          accept;

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        assign req_byte[g]  = req_data[8*g +: 8];
        assign req_ready[g] = accept && (sel_idx == IW'(g));
    end

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (rr_last),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef UART_ARB_LOCK_EN
    // While locked, the owner is the last grantee; the rr pointer only
    // moves once a packet's last byte has gone out.
    logic          lock_q;
    logic [IW-1:0] rr_q;

    assign rr_last   = rr_q;
    assign sel_valid = lock_q ? req_valid[grant_q] : pick_valid;
    assign sel_idx   = lock_q ? grant_q : pick_idx;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            lock_q <= 1'b0;
            rr_q   <= IW'(N_REQ - 1);
        end else if (accept) begin
            if (req_last[sel_idx]) begin
                lock_q <= 1'b0;
                rr_q   <= sel_idx;
            end else begin
                lock_q <= 1'b1;
            end
        end
    end
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign rr_last     = grant_q;
    assign sel_valid   = pick_valid;
    assign sel_idx     = pick_idx;
`endif

    assign accept = (state_q == ARB_IDLE) && sel_valid && !sys_rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        data_d  = data_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    data_d  = req_byte[sel_idx];
                    grant_d = sel_idx;
                    state_d = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                cnt_d   = '0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            grant_q <= IW'(N_REQ - 1);
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    assign pi_data  = data_q;
    assign pi_flag  = (state_q == ARB_LOAD);
    assign grant_id = grant_q;
    assign busy     = (state_q != ARB_IDLE) || accept;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed scoreboard bench for uart_tx_arb with a 100-cycle
// frame; expected lock-mode order follows UART_ARB_LOCK_EN.
module tb_uart_tx_arb;

    localparam int unsigned N = 4;

    logic          sys_clk;
    logic          sys_rst;
    logic [N-1:0]  req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic [7:0]    pi_data;
    logic          pi_flag;
    logic [1:0]    grant_id;
    logic          busy;

    uart_tx_arb #(
        .N_REQ    (N),
        .UART_BPS (100_000),
        .CLK_FREQ (1_000_000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0]  data;
        int unsigned id;
        int unsigned gap;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;
    int unsigned last_flag   = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per pi_flag strobe.
    always @(negedge sys_clk) begin
        if (req_ready != '0)
            check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (pi_flag) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_flag: got pi_flag with pi_data %02h, required none", pi_data);
            end else begin
                e = sb.pop_front();
                check("pi_data", 32'(pi_data), 32'(e.data));
                check("grant_id", 32'(grant_id), e.id);
                if (e.gap != 0)
                    check("flag_gap", cyc - last_flag, e.gap);
            end
            last_flag = cyc;
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input int unsigned id, input int unsigned gap);
        exp_t r;
        r.data = d;
        r.id   = id;
        r.gap  = gap;
        return r;
    endfunction

    task automatic await_ready(input logic [1:0] idx, input int budget);
        int n = 0;
        @(negedge sys_clk);
        while (!req_ready[idx] && n < budget) begin
            n++;
            @(negedge sys_clk);
        end
        check("await_ready", 32'(req_ready[idx]), 32'd1);
    endtask

    task automatic wait_sb_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("sb_drain", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic any_rdy;
        logic any_busy;

        sys_rst   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_flag", 32'(pi_flag), 32'd0);
        check("rst_data", 32'(pi_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd3);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;

        // Single requester 2 offering 0xA5.
        @(posedge sys_clk); #1;
        sb.push_back(mk(8'hA5, 2, 0));
        req_data[23:16] = 8'hA5;
        req_valid[2]    = 1'b1;
        await_ready(2, 5);
        check("single_busy", 32'(busy), 32'd1);
        fork
            begin
                @(posedge sys_clk); #1;
                req_valid[2] = 1'b0;
            end
        join_none
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge sys_clk);
            if (n == 1) check("ready_pulse_1cyc", 32'(req_ready), 32'd0);
        end
        check("busy_len", n, 32'd102);
        wait_sb_empty(10);

        // All four held valid: 0x10,0x11,0x12,0x13,0x10 at 102-cycle spacing.
        do_reset();
        sb.push_back(mk(8'h10, 0, 0));
        sb.push_back(mk(8'h11, 1, 102));
        sb.push_back(mk(8'h12, 2, 102));
        sb.push_back(mk(8'h13, 3, 102));
        sb.push_back(mk(8'h10, 0, 102));
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        wait_sb_empty(700);

        // Req 0 stays valid; req 1 re-raises during WAIT and must win next.
        @(posedge sys_clk); #1;
        req_valid = 4'b0001;
        repeat (20) @(posedge sys_clk);
        #1;
        req_data[15:8] = 8'h21;
        req_valid[1]   = 1'b1;
        sb.push_back(mk(8'h21, 1, 102));
        sb.push_back(mk(8'h10, 0, 102));
        await_ready(1, 300);
        @(posedge sys_clk); #1;
        req_valid[1] = 1'b0;
        await_ready(0, 300);
        @(posedge sys_clk); #1;
        req_valid[0] = 1'b0;
        wait_sb_empty(10);

        // Req 0 sends a 3-byte packet while req 1 sends two single bytes.
        do_reset();
`ifdef UART_ARB_LOCK_EN
        sb.push_back(mk(8'hA0, 0, 0));
        sb.push_back(mk(8'hA1, 0, 102));
        sb.push_back(mk(8'hA2, 0, 102));
        sb.push_back(mk(8'hB0, 1, 102));
        sb.push_back(mk(8'hB1, 1, 102));
`else
        sb.push_back(mk(8'hA0, 0, 0));
        sb.push_back(mk(8'hB0, 1, 102));
        sb.push_back(mk(8'hA1, 0, 102));
        sb.push_back(mk(8'hB1, 1, 102));
        sb.push_back(mk(8'hA2, 0, 102));
`endif
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    req_data[7:0] = 8'hA0 + 8'(k);
                    req_last[0]   = (k == 2);
                    req_valid[0]  = 1'b1;
                    await_ready(0, 1000);
                    @(posedge sys_clk); #1;
                end
                req_valid[0] = 1'b0;
                req_last[0]  = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    req_data[15:8] = 8'hB0 + 8'(k);
                    req_last[1]    = 1'b1;
                    req_valid[1]   = 1'b1;
                    await_ready(1, 1000);
                    @(posedge sys_clk); #1;
                end
                req_valid[1] = 1'b0;
                req_last[1]  = 1'b0;
            end
        join
        wait_sb_empty(10);

        // Reset 50 cycles into WAIT with req 2 still pending.
        req_data[23:16] = 8'h5C;
        req_valid[2]    = 1'b1;
        sb.push_back(mk(8'h5C, 2, 0));
        wait_sb_empty(300);
        repeat (50) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_grant", 32'(grant_id), 32'd3);
        check("midrst_flag", 32'(pi_flag), 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        sb.push_back(mk(8'h5C, 2, 0));
        @(negedge sys_clk);
        check("post_rst_accept", 32'(req_ready), 32'h4);
        @(posedge sys_clk); #1;
        req_valid[2] = 1'b0;
        wait_sb_empty(10);

        // Req 3 offers during WAIT and withdraws before IDLE.
        any_rdy  = 1'b0;
        any_busy = 1'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        req_data[31:24] = 8'h77;
        req_valid[3]    = 1'b1;
        repeat (30) begin
            @(negedge sys_clk);
            any_rdy = any_rdy | req_ready[3];
        end
        @(posedge sys_clk); #1;
        req_valid[3] = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge sys_clk);
            any_rdy = any_rdy | req_ready[3];
        end
        check("withdraw_idle", 32'(busy), 32'd0);
        repeat (150) begin
            @(negedge sys_clk);
            any_rdy  = any_rdy | req_ready[3];
            any_busy = any_busy | busy;
        end
        check("withdraw_no_ready", 32'(any_rdy), 32'd0);
        check("withdraw_no_busy", 32'(any_busy), 32'd0);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
